// File: rtl/sram_controller.sv
// Bridges a 32-bit word access onto a 16-bit asynchronous SRAM as two halfword
// phases (low half, then high half), stalling the requester until the word completes.
module sram_controller #(
  parameter int BASE_ADDR    = 1024,
  parameter int PHASE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_LO = 3'd1,
    WR_HI = 3'd2,
    RD_LO = 3'd3,
    RD_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int            CW       = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [16:0]   word_q, word_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [17:0]   addr_q, addr_d;
  logic          we_n_q, we_n_d;
  logic [15:0]   dq_q, dq_d;
  logic [16:0]   word_in;
  logic          phase_last;

  // Word index wraps modulo 2^17 after removing the base offset.
  assign word_in    = 17'((address - 32'(BASE_ADDR)) >> 2);
  assign phase_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (wr_en) begin
          state_d = WR_LO;
          word_d  = word_in;
          wdata_d = write_data;
        end else if (rd_en) begin
          state_d = RD_LO;
          word_d  = word_in;
        end
      end
      WR_LO, WR_HI, RD_LO, RD_HI: begin
        if (phase_last) begin
          cnt_d = '0;
          case (state_q)
            WR_LO:   state_d = WR_HI;
            RD_LO: begin
              state_d        = RD_HI;
              rdata_d[15:0]  = SRAM_DQ;
            end
            RD_HI: begin
              state_d        = DONE;
              rdata_d[31:16] = SRAM_DQ;
            end
            default: state_d = DONE;
          endcase
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pins are registered from the upcoming state so they are stable for the whole phase.
    we_n_d = 1'b1;
    dq_d   = dq_q;
    addr_d = addr_q;
    case (state_d)
      WR_LO: begin
        we_n_d = 1'b0;
        dq_d   = wdata_d[15:0];
        addr_d = {word_d, 1'b0};
      end
      WR_HI: begin
        we_n_d = 1'b0;
        dq_d   = wdata_d[31:16];
        addr_d = {word_d, 1'b1};
      end
      RD_LO:   addr_d = {word_d, 1'b0};
      RD_HI:   addr_d = {word_d, 1'b1};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      we_n_q  <= 1'b1;
      dq_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      we_n_q  <= we_n_d;
      dq_q    <= dq_d;
    end
  end

  // A single register gates both WE_N and the DQ driver, so bus ownership never overlaps.
  assign SRAM_DQ     = we_n_q ? 16'bz : dq_q;
  assign SRAM_WE_N   = we_n_q;
  assign SRAM_ADDR   = addr_q;
  assign SRAM_UB_N   = 1'b0;
  assign SRAM_LB_N   = 1'b0;
  assign SRAM_CE_N   = 1'b0;
  assign SRAM_OE_N   = 1'b0;
  assign read_data   = rdata_q;
  assign ready       = ~((rd_en | wr_en) & (state_q != DONE));
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (1-cycle and 3-cycle phases), each
// with its own behavioural asynchronous SRAM on the DQ bus.
module tb_sram_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wr_en, rd_en, sel;
  logic [31:0] address, write_data;

  logic        wr1, rd1, wr3, rd3;
  assign wr1 = wr_en & ~sel;
  assign rd1 = rd_en & ~sel;
  assign wr3 = wr_en & sel;
  assign rd3 = rd_en & sel;

  logic [31:0] rdata1, rdata3;
  logic        ready1, ready3;
  wire  [15:0] dq1, dq3;
  logic [17:0] addr1, addr3;
  logic        ub1, lb1, we1, ce1, oe1;
  logic        ub3, lb3, we3, ce3, oe3;
  logic [2:0]  dbg1, dbg3;

  sram_controller #(.BASE_ADDR(1024), .PHASE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1), .address(address),
    .write_data(write_data), .read_data(rdata1), .ready(ready1), .SRAM_DQ(dq1),
    .SRAM_ADDR(addr1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_WE_N(we1),
    .SRAM_CE_N(ce1), .SRAM_OE_N(oe1), .dbg_state_o(dbg1)
  );

  sram_controller #(.BASE_ADDR(1024), .PHASE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .wr_en(wr3), .rd_en(rd3), .address(address),
    .write_data(write_data), .read_data(rdata3), .ready(ready3), .SRAM_DQ(dq3),
    .SRAM_ADDR(addr3), .SRAM_UB_N(ub3), .SRAM_LB_N(lb3), .SRAM_WE_N(we3),
    .SRAM_CE_N(ce3), .SRAM_OE_N(oe3), .dbg_state_o(dbg3)
  );

  // Asynchronous SRAM models: drive DQ whenever not being written (OE_N tied low).
  logic [15:0] mem1 [0:262143];
  logic [15:0] mem3 [0:262143];
  assign dq1 = we1 ? mem1[addr1] : 16'bz;
  assign dq3 = we3 ? mem3[addr3] : 16'bz;
  always @(posedge clk) if (!we1) mem1[addr1] <= dq1;
  always @(posedge clk) if (!we3) mem3[addr3] <= dq3;

  logic [31:0] rdata_m;
  logic        ready_m, we_m;
  logic [17:0] addr_m;
  logic [15:0] dq_m;
  assign rdata_m = sel ? rdata3 : rdata1;
  assign ready_m = sel ? ready3 : ready1;
  assign we_m    = sel ? we3 : we1;
  assign addr_m  = sel ? addr3 : addr1;
  assign dq_m    = sel ? dq3 : dq1;

  typedef struct {
    bit          sel;
    bit          wr;
    bit          rd;
    bit          b2b;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs [0:31];
  int          nv;
  logic [31:0] ref_mem [bit [17:0]];
  logic [31:0] last_rd [0:1];
  logic [31:0] exp_q [$];
  int          vectors, miscompares;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] word_of(input logic [31:0] a);
    logic [31:0] q;
    q = (a - 32'd1024) / 32'd4;
    return q[16:0];
  endfunction

  function automatic logic [15:0] mem_rd(input bit s, input logic [17:0] a);
    return s ? mem3[a] : mem1[a];
  endfunction

  task automatic add_vec(input bit s, input bit w, input bit r, input bit b,
                         input logic [31:0] a, input logic [31:0] d);
    vec_t v;
    v.sel = s; v.wr = w; v.rd = r; v.b2b = b; v.addr = a; v.wdata = d;
    if (w) begin
      ref_mem[{s, word_of(a)}] = d;
      v.exp_rdata = last_rd[s];
    end else begin
      v.exp_rdata = ref_mem.exists({s, word_of(a)}) ? ref_mem[{s, word_of(a)}] : 32'h0;
      last_rd[s]  = v.exp_rdata;
    end
    vecs[nv] = v;
    nv++;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        v;
    int          p, stall, we_low, addr_err;
    logic [16:0] w;
    logic [17:0] exp_a;
    logic [31:0] exp_rd, off;
    logic [15:0] hi_before;

    vectors = 0; miscompares = 0; nv = 0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;

    add_vec(0, 1, 0, 0, 32'd1024, 32'hDEAD_BEEF);
    add_vec(0, 0, 1, 0, 32'd1024, 32'h0);
    add_vec(0, 1, 1, 0, 32'd1028, 32'h1234_5678);
    add_vec(0, 0, 1, 0, 32'd1028, 32'h0);
    add_vec(1, 1, 0, 0, 32'd1032, 32'hA5A5_3C3C);
    add_vec(1, 0, 1, 0, 32'd1032, 32'h0);
    add_vec(0, 1, 0, 0, 32'd1024 + 32'h0008_0000, 32'hCAFE_F00D);
    add_vec(0, 0, 1, 0, 32'd1024, 32'h0);
    add_vec(0, 1, 0, 0, 32'd1024, $urandom);
    add_vec(0, 1, 0, 1, 32'd1028, $urandom);
    add_vec(0, 0, 1, 1, 32'd1024, 32'h0);
    add_vec(0, 0, 1, 1, 32'd1028, 32'h0);
    for (int k = 0; k < 2; k++) begin
      off = 32'($urandom_range(16, 4000)) * 32'd4;
      add_vec(0, 1, 0, 0, 32'd1024 + off, $urandom);
      add_vec(0, 0, 1, 1, 32'd1024 + off, 32'h0);
    end
    off = 32'($urandom_range(16, 4000)) * 32'd4;
    add_vec(1, 1, 0, 0, 32'd1024 + off, $urandom);
    add_vec(1, 0, 1, 1, 32'd1024 + off, 32'h0);

    // Clock/reset
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; sel = 1'b0;
    address = 32'h0; write_data = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_read_data", rdata1, 32'h0);
    check("rst_we_n", {31'h0, we1}, 32'h1);
    check("rst_addr", {14'h0, addr1}, 32'h0);
    check("rst_ready", {31'h0, ready1}, 32'h1);
    check("rst_state", {29'h0, dbg1}, 32'h0);
    check("rst_tied_pins", {28'h0, ub1, lb1, ce1, oe1}, 32'h0);
    check("rst_tied_pins3", {28'h0, ub3, lb3, ce3, oe3}, 32'h0);
    check("rst_read_data3", rdata3, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < nv; i++) begin
      v = vecs[i];
      if (!v.b2b) begin
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        #1;
        check($sformatf("idle_ready[%0d]", i), {31'h0, ready_m}, 32'h1);
        check($sformatf("idle_we_n[%0d]", i), {31'h0, we_m}, 32'h1);
        sel = v.sel;
      end
      wr_en = v.wr; rd_en = v.rd; address = v.addr; write_data = v.wdata;
      exp_q.push_back(v.exp_rdata);
      if (v.b2b) @(negedge clk);
      #1;

      p = v.sel ? 3 : 1;
      w = word_of(v.addr);
      stall = 0; we_low = 0; addr_err = 0;
      while (ready_m == 1'b0 && stall < 40) begin
        if (stall >= 1) begin
          exp_a = {w, ((stall - 1) >= p) ? 1'b1 : 1'b0};
          if (addr_m !== exp_a) addr_err++;
        end
        if (we_m == 1'b0) we_low++;
        stall++;
        @(negedge clk);
        #1;
      end

      exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      check($sformatf("stall[%0d]", i), 32'(stall), 32'(1 + 2 * p));
      check($sformatf("read_data[%0d]", i), rdata_m, exp_rd);
      check($sformatf("we_low_cycles[%0d]", i), 32'(we_low), v.wr ? 32'(2 * p) : 32'h0);
      check($sformatf("addr_seq_errs[%0d]", i), 32'(addr_err), 32'h0);
      check($sformatf("done_we_n[%0d]", i), {31'h0, we_m}, 32'h1);
      if (v.wr)
        check($sformatf("sram_word[%0d]", i),
              {mem_rd(v.sel, {w, 1'b1}), mem_rd(v.sel, {w, 1'b0})}, v.wdata);
    end

    // Reset in the middle of the high-half write phase.
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    sel = 1'b0;
    hi_before = mem1[7];
    wr_en = 1'b1; address = 32'd1036; write_data = 32'h0BAD_F00D;
    #1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre_reset_we_n", {31'h0, we1}, 32'h0);
    check("pre_reset_addr", {14'h0, addr1}, 32'd7);
    rst = 1'b0;
    #1;
    check("abort_we_n", {31'h0, we1}, 32'h1);
    check("abort_read_data", rdata1, 32'h0);
    check("abort_addr", {14'h0, addr1}, 32'h0);
    check("abort_ready_req", {31'h0, ready1}, 32'h0);
    check("abort_dq_released", {16'h0, dq1}, {16'h0, mem1[0]});
    wr_en = 1'b0;
    #1;
    check("abort_ready_noreq", {31'h0, ready1}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("no_retry_ready[%0d]", k), {31'h0, ready1}, 32'h1);
      check($sformatf("no_retry_we_n[%0d]", k), {31'h0, we1}, 32'h1);
    end
    check("abort_lo_written", {16'h0, mem1[6]}, 32'h0000_F00D);
    check("abort_hi_untouched", {16'h0, mem1[7]}, {16'h0, hi_before});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
